// File: rtl/s_reg_seq.sv
// s_reg_seq: handshake-loaded serial shift register sequencer with programmable bit period.
// Shifts MSB-first, capturing sin or rotating, then presents the final word on rx_data.
module s_reg_seq #(
    parameter int WIDTH = 8,
    parameter int DIV   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tx_valid,
    output logic             tx_ready,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             mode,
    input  logic             abort,
    input  logic             sin,
    output logic             sout,
    output logic             shift_en,
    output logic             busy,
    output logic             rx_valid,
    output logic [WIDTH-1:0] rx_data
);
    localparam int BW = $clog2(WIDTH);
    localparam int DW = DIV > 1 ? $clog2(DIV) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sreg_q, sreg_d, rx_data_q, rx_data_d, shifted;
    logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [DW-1:0]    div_cnt_q, div_cnt_d;
    logic             mode_q, mode_d, wrap, tick;

    assign wrap    = div_cnt_q == DW'(DIV - 1);
    // abort beats a coinciding shift edge, so it also suppresses shift_en
    assign tick    = state_q == SHIFT && wrap && !abort;
    assign shifted = {sreg_q[WIDTH-2:0], mode_q ? sreg_q[WIDTH-1] : sin};

    always_comb begin
        state_d   = state_q;
        sreg_d    = sreg_q;
        rx_data_d = rx_data_q;
        bit_cnt_d = bit_cnt_q;
        div_cnt_d = div_cnt_q;
        mode_d    = mode_q;
        case (state_q)
            IDLE: if (tx_valid) begin
                state_d   = SHIFT;
                sreg_d    = tx_data;
                mode_d    = mode;
                bit_cnt_d = '0;
                div_cnt_d = '0;
            end
            SHIFT: if (abort) begin
                state_d = IDLE;
            end else begin
                div_cnt_d = wrap ? '0 : div_cnt_q + 1'b1;
                if (tick) begin
                    sreg_d    = shifted;
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == BW'(WIDTH - 1)) begin
                        state_d   = DONE;
                        rx_data_d = shifted;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            sreg_q    <= '0;
            rx_data_q <= '0;
            bit_cnt_q <= '0;
            div_cnt_q <= '0;
            mode_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            sreg_q    <= sreg_d;
            rx_data_q <= rx_data_d;
            bit_cnt_q <= bit_cnt_d;
            div_cnt_q <= div_cnt_d;
            mode_q    <= mode_d;
        end
    end

    assign tx_ready = state_q == IDLE;
    assign busy     = state_q != IDLE;
    assign rx_valid = state_q == DONE;
    assign shift_en = tick;
    assign sout     = sreg_q[WIDTH-1];
    assign rx_data  = rx_data_q;
endmodule

// File: tb/tb_s_reg_seq.sv
// tb_s_reg_seq: scoreboard bench for s_reg_seq, one instance at DIV=4 and one at DIV=1.
module tb_s_reg_seq;
    logic clk, rst;
    logic tx_valid, tx_ready, mode, abort, sin, sout, shift_en, busy, rx_valid;
    logic [7:0] tx_data, rx_data;
    logic b_tx_valid, b_tx_ready, b_sin, b_sout, b_shift_en, b_busy, b_rx_valid;
    logic [7:0] b_tx_data, b_rx_data;

    typedef struct {
        logic [7:0] d;
        int         c;
    } exp_t;

    exp_t qa[$], qb[$];
    exp_t ea, eb;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    s_reg_seq #(.WIDTH(8), .DIV(4)) dut (
        .clk(clk), .rst(rst), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
        .mode(mode), .abort(abort), .sin(sin), .sout(sout), .shift_en(shift_en),
        .busy(busy), .rx_valid(rx_valid), .rx_data(rx_data)
    );

    s_reg_seq #(.WIDTH(8), .DIV(1)) dut1 (
        .clk(clk), .rst(rst), .tx_valid(b_tx_valid), .tx_ready(b_tx_ready), .tx_data(b_tx_data),
        .mode(1'b0), .abort(1'b0), .sin(b_sin), .sout(b_sout), .shift_en(b_shift_en),
        .busy(b_busy), .rx_valid(b_rx_valid), .rx_data(b_rx_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    // scoreboard: every rx_valid pulse must match the oldest pending expectation
    always @(negedge clk) begin
        if (!rst && rx_valid) begin
            if (qa.size() == 0) chk("a_rx_unexpected", 1, 0);
            else begin
                ea = qa.pop_front();
                chk("a_rx_data", rx_data, ea.d);
                chk("a_rx_cycle", cyc, ea.c);
            end
        end
        if (!rst && b_rx_valid) begin
            if (qb.size() == 0) chk("b_rx_unexpected", 1, 0);
            else begin
                eb = qb.pop_front();
                chk("b_rx_data", b_rx_data, eb.d);
                chk("b_rx_cycle", cyc, eb.c);
            end
        end
    end

    task automatic accept_a(input logic [7:0] data, input logic md);
        @(negedge clk);
        tx_valid = 1'b1;
        tx_data  = data;
        mode     = md;
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
        tx_data  = ~data;
        mode     = ~md;
    endtask

    task automatic run_a(input logic [7:0] data, input logic md, input logic [7:0] sin_w,
                         input logic [7:0] exp_rx);
        logic [7:0] r;
        exp_t       e;
        sin = sin_w[7];
        accept_a(data, md);
        e.d = exp_rx;
        e.c = cyc + 32;
        qa.push_back(e);
        r = data;
        for (int c = 0; c < 32; c++) begin
            @(negedge clk);
            chk("a_sout", sout, r[7]);
            chk("a_shift_en", shift_en, c % 4 == 3);
            chk("a_busy", busy, 1);
            chk("a_tx_ready", tx_ready, 0);
            if (c % 4 == 0) sin = sin_w[7 - c / 4];
            if (c % 4 == 3) r = {r[6:0], md ? r[7] : sin_w[7 - c / 4]};
        end
        @(negedge clk);
        chk("a_done_rx_valid", rx_valid, 1);
        chk("a_done_busy", busy, 1);
        chk("a_done_tx_ready", tx_ready, 0);
        @(negedge clk);
        chk("a_idle_tx_ready", tx_ready, 1);
        chk("a_idle_busy", busy, 0);
        chk("a_idle_rx_valid", rx_valid, 0);
        chk("a_rx_hold", rx_data, exp_rx);
    endtask

    initial begin
        logic [7:0] w1, w2;
        logic       es;
        rst = 1'b1;
        tx_valid = 1'b0; tx_data = '0; mode = 1'b0; abort = 1'b0; sin = 1'b0;
        b_tx_valid = 1'b0; b_tx_data = '0; b_sin = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_tx_ready", tx_ready, 1);
        chk("rst_sout", sout, 0);
        chk("rst_shift_en", shift_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_rx_data", rx_data, 0);
        rst = 1'b0;

        run_a(8'hA5, 1'b0, 8'hFF, 8'hFF);
        run_a(8'h3C, 1'b1, 8'h55, 8'h3C);
        run_a(8'h00, 1'b0, 8'h5A, 8'h5A);

        // back-to-back at DIV=1 with tx_valid held high
        w1 = 8'h81;
        w2 = 8'h7E;
        @(negedge clk);
        b_tx_valid = 1'b1;
        b_tx_data  = w1;
        @(posedge clk);
        #1;
        b_tx_data = w2;
        eb.d = 8'h00; eb.c = cyc + 8;  qb.push_back(eb);
        eb.d = 8'h00; eb.c = cyc + 18; qb.push_back(eb);
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            es = c >= 1 && c <= 8 ? w1[8 - c] : c >= 11 && c <= 18 ? w2[18 - c] : 1'b0;
            chk("b_sout", b_sout, es);
            chk("b_tx_ready", b_tx_ready, c == 10 || c == 20);
            chk("b_rx_valid", b_rx_valid, c == 9 || c == 19);
            chk("b_shift_en", b_shift_en, (c >= 1 && c <= 8) || (c >= 11 && c <= 18));
            if (c == 19) b_tx_valid = 1'b0;
        end

        // abort after the third shift_en pulse
        sin = 1'b0;
        accept_a(8'hA5, 1'b0);
        for (int c = 0; c < 12; c++) @(negedge clk);
        chk("ab_third_shift_en", shift_en, 1);
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("ab_tx_ready", tx_ready, 1);
        chk("ab_busy", busy, 0);
        chk("ab_sreg", dut.sreg_q, 8'h28);
        chk("ab_sout", sout, 0);
        repeat (40) @(negedge clk);
        chk("ab_rx_data_kept", rx_data, 8'h5A);

        // asynchronous reset mid-transfer
        accept_a(8'hA5, 1'b0);
        repeat (10) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("mr_sout", sout, 0);
        chk("mr_busy", busy, 0);
        chk("mr_tx_ready", tx_ready, 1);
        chk("mr_rx_data", rx_data, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        chk("mr_rx_data_after", rx_data, 0);

        chk("sb_a_empty", qa.size(), 0);
        chk("sb_b_empty", qb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/s_reg_seq.md
Name: s_reg_seq

Overview:
- Sequencer for an 8-bit-class serial shift register.
- Accepts a parallel word over a valid/ready handshake and loads it into the register.
- Shifts the word out MSB-first at a programmable bit rate, optionally capturing serial input (SIPO) or rotating (recirculate). It then presents the final register contents as a received word.
- Sits between a parallel producer/consumer and a serial pin pair; it owns all shift timing.

Parameters:
- WIDTH, 8, shift register length in bits (must be >= 2).
- DIV, 4, clock cycles per bit period (must be >= 1); DIV=1 shifts every cycle.

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  asynchronous reset, active-high.
- tx_valid  in  1  producer has a word on tx_data.
- tx_ready  out  1  sequencer can accept a word.
- tx_data  in  WIDTH  parallel word to load.
- mode  in  1  0 = shift-in from sin, 1 = rotate (MSB recirculates to LSB); sampled at accept.
- abort  in  1  cancel the transfer in progress.
- sin  in  1  serial input, sampled only on shift edges.
- sout  out  1  serial output = register MSB.
- shift_en  out  1  high in the cycle whose closing edge performs a shift.
- busy  out  1  high in SHIFT or DONE.
- rx_valid  out  1  one-cycle pulse: rx_data updated.
- rx_data  out  WIDTH  register contents after the last completed transfer.

Behaviour:
- Reset (rst=1, asynchronous): state IDLE, shift reg=0, bit_cnt=0, div_cnt=0, mode latch=0, rx_data=0.
  - Resulting outputs: tx_ready=1, sout=0, shift_en=0, busy=0, rx_valid=0.
  - Reset mid-transfer discards everything immediately; no rx_valid.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - tx_ready=1, busy=0.
  - On tx_valid at an edge: reg<=tx_data, mode latch<=mode, bit_cnt<=0, div_cnt<=0, go to SHIFT.
  - abort in IDLE has no effect.
- SHIFT:
  - tx_ready=0, busy=1.
  - div_cnt counts 0..DIV-1 and wraps.
  - shift_en = (div_cnt==DIV-1).
  - On a shift edge: reg<={reg[WIDTH-2:0], latched_mode ? reg[WIDTH-1] : sin}; bit_cnt++.
  - The shift edge with bit_cnt==WIDTH-1 goes to DONE and loads rx_data with the post-shift value.
- DONE: exactly one cycle, rx_valid=1, busy=1, tx_ready=0; then go to IDLE.
- Latency: if the word is accepted at edge E0, rx_valid is high in cycle WIDTH*DIV+1 after E0, i.e. the cycle between edges E0+WIDTH*DIV and E0+WIDTH*DIV+1.
- sout holds each bit for exactly DIV cycles; the first bit (tx_data MSB) appears in the cycle after acceptance.
- abort=1 in SHIFT:
  - Next edge goes to IDLE; reg keeps its current value, rx_data is unchanged, no rx_valid.
  - If abort and a shift edge coincide, abort wins: no shift, no DONE.
- abort in DONE is ignored; rx_valid still pulses.
- Back-to-back transfers: a new word is accepted no earlier than the cycle after DONE, so there is a minimum 1-cycle gap between transfers.
- tx_data and mode changes while busy are ignored.
- Rotate mode: after WIDTH shifts the register equals the original word.

Test Plan:
- Reset mid-transfer: WIDTH=8, DIV=4, accept 8'hA5, assert rst after 10 cycles -> sout=0, busy=0, tx_ready=1 immediately (asynchronously); no rx_valid afterwards; rx_data=0.
- Shift mode: 8'hA5, mode=0, sin=1 constant -> sout=1,0,1,0,0,1,0,1, each held 4 cycles; 8 shift_en pulses spaced 4 cycles; rx_valid in cycle 33 after accept; rx_data=8'hFF.
- Rotate mode: 8'h3C, mode=1 -> sout=0,0,1,1,1,1,0,0; rx_data=8'h3C; sin toggling has no effect.
- SIPO capture: 8'h00, mode=0, sin driven MSB-first with 8'h5A, changed once per bit period -> rx_data=8'h5A.
- Abort: 8'hA5, mode=0, sin=0, abort asserted after the 3rd shift_en -> IDLE next edge, no rx_valid, tx_ready=1, internal reg=8'h28, sout=0.
- Back-to-back with DIV=1: tx_valid held high with 8'h81 then 8'h7E -> rx_valid at cycle 9 (rx_data=8'h00 with sin=0); second word accepted in the IDLE cycle after DONE; tx_ready low for 9 cycles per transfer; second sout sequence 0,1,1,1,1,1,1,0.
